pipeline_ctrl: RTL

//  Central hazard/sequencing controller for the 5-stage rv64IM pipeline.
//  - Drives stall/flush of PC, if_id, id_ex, ex_mem and mem_wb from hazard inputs.
//  - Handles load-use hazards, EX-resolved redirects, multi-cycle mul/div and data-memory wait states.
//  - Implements the exit/halt and memory-timeout error stop.

---
 rtl/pipeline_ctrl_pkg.sv | 52 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 28 ++
 rtl/pipeline_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   ctrl_state_t : controller FSM encoding
//   ctrl_out_t   : bundle of the stall/flush strobes driven to the pipeline
//   OUT_*        : canned strobe patterns used by the controller FSM
package pipeline_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 256;
  localparam int CNT_W_DEF       = 32;
  localparam int REG_ADDR_W      = 5;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_DIV_WAIT = 2'd2,
    CTRL_HALT     = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_out_t;

  localparam ctrl_out_t OUT_IDLE = '0;

  // Everything up to ex_mem frozen, bubble falls into mem_wb.
  // Shared by the data-memory wait and the halted state.
  localparam ctrl_out_t OUT_FREEZE_MEM = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0, id_ex_stall: 1'b1,
    id_ex_flush: 1'b0, ex_mem_stall: 1'b1, ex_mem_flush: 1'b0, mem_wb_flush: 1'b1};

  // Front end frozen while mul/div iterates, bubble falls into ex_mem.
  localparam ctrl_out_t OUT_FREEZE_DIV = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0, id_ex_stall: 1'b1,
    id_ex_flush: 1'b0, ex_mem_stall: 1'b0, ex_mem_flush: 1'b1, mem_wb_flush: 1'b0};

  // Taken branch/jump: kill the two younger instructions.
  localparam ctrl_out_t OUT_REDIRECT = '{
    pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1, id_ex_stall: 1'b0,
    id_ex_flush: 1'b1, ex_mem_stall: 1'b0, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

  // Load-use: hold fetch/decode one cycle, bubble into id_ex.
  localparam ctrl_out_t OUT_LOAD_USE = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0, id_ex_stall: 1'b0,
    id_ex_flush: 1'b1, ex_mem_stall: 1'b0, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Ports:
//   id_rs1, id_rs2         : source registers of the ID instruction
//   id_use_rs1, id_use_rs2 : ID instruction actually reads that source
//   ex_load, ex_rd         : id_ex holds a load writing ex_rd
//   load_use               : ID must wait one cycle for the load result
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is never a real dependency.
  assign load_use = ex_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage rv64IM pipeline.
// Ports:
//   clock, reset_n         : core clock, asynchronous active-low reset
//   id_*                   : source operands of the instruction in ID
//   ex_load, ex_rd         : load in id_ex and its destination
//   ex_redirect            : taken branch/jump resolved in EX
//   ex_muldiv, muldiv_done : multi-cycle mul/div in EX and its completion
//   mem_req, mem_ready     : data-memory access in ex_mem and its completion
//   wb_exit                : exit instruction reached write-back
//   *_stall / *_flush      : combinational pipeline register controls
//   halted, mem_err        : core stopped / memory timeout (sticky)
//   stall_cycles           : saturating count of PC-stall cycles while running
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  ex_muldiv,
  input  logic                  muldiv_done,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  wb_exit,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  halted,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cycles
);

  // wait_cnt counts every mem_ready=0 cycle of one access, including the
  // RUN cycle that first sees the miss, and never needs to exceed MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              err_set;
  logic              load_use;
  ctrl_out_t         ctl;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_load    (ex_load),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  always_comb begin
    ctl       = OUT_IDLE;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    // Strobes are held inactive while reset is asserted so the pipeline sees
    // an idle controller immediately, whatever the hazard inputs are doing.
    if (reset_n) begin
      unique case (state)
        CTRL_RUN: begin
          if (wb_exit) begin
            ctl       = OUT_FREEZE_MEM;
            state_nxt = CTRL_HALT;
          end else if (mem_req && !mem_ready) begin
            ctl       = OUT_FREEZE_MEM;
            state_nxt = CTRL_MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else if (ex_muldiv && !muldiv_done) begin
            ctl       = OUT_FREEZE_DIV;
            state_nxt = CTRL_DIV_WAIT;
          end else if (ex_redirect) begin
            // The load-use victim is on the wrong path, so no stall is needed.
            ctl = OUT_REDIRECT;
          end else if (load_use) begin
            ctl = OUT_LOAD_USE;
          end
        end
        CTRL_MEM_WAIT: begin
          if (mem_ready) begin
            state_nxt = CTRL_RUN;
            wait_nxt  = '0;
          end else begin
            ctl = OUT_FREEZE_MEM;
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
              err_set   = 1'b1;
              state_nxt = CTRL_HALT;
              wait_nxt  = '0;
            end else begin
              wait_nxt = wait_cnt + WAIT_W'(1);
            end
          end
        end
        CTRL_DIV_WAIT: begin
          // Releasing on the done cycle lets the result advance into ex_mem.
          if (muldiv_done) begin
            state_nxt = CTRL_RUN;
          end else begin
            ctl = OUT_FREEZE_DIV;
          end
        end
        CTRL_HALT: begin
          ctl = OUT_FREEZE_MEM;
        end
        default: begin
          state_nxt = CTRL_RUN;
        end
      endcase
    end
  end

  assign pc_stall     = ctl.pc_stall;
  assign if_id_stall  = ctl.if_id_stall;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_stall  = ctl.id_ex_stall;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_stall = ctl.ex_mem_stall;
  assign ex_mem_flush = ctl.ex_mem_flush;
  assign mem_wb_flush = ctl.mem_wb_flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CTRL_RUN;
      wait_cnt     <= '0;
      halted       <= 1'b0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // HALT is only left through reset, so halted simply tracks entry.
      halted   <= (state_nxt == CTRL_HALT);
      if (err_set) begin
        mem_err <= 1'b1;
      end
      if (pc_stall && (state != CTRL_HALT) && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule
